// File: rtl/instruction_memory.sv
// Read-only boot instruction store for the MIPS fetch stage.
// Word-addressed, one-cycle registered read, output cleared asynchronously by rst.
module instruction_memory #(
    parameter int                ADDR_W   = 10,
    parameter int                DATA_W   = 32,
    parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data
);

    // Boot program: a short ALU/memory exercise ending in a jump-to-self halt loop.
    function automatic logic [DATA_W-1:0] rom_word(input logic [ADDR_W-1:0] index);
        logic [DATA_W-1:0] word;
        word = NOP_WORD;
        case (index)
            ADDR_W'(0): word = DATA_W'(32'h2008_0005);  // addi $t0,$zero,5
            ADDR_W'(1): word = DATA_W'(32'h2009_0003);  // addi $t1,$zero,3
            ADDR_W'(2): word = DATA_W'(32'h0109_5020);  // add  $t2,$t0,$t1
            ADDR_W'(3): word = DATA_W'(32'h0109_5822);  // sub  $t3,$t0,$t1
            ADDR_W'(4): word = DATA_W'(32'h0109_6024);  // and  $t4,$t0,$t1
            ADDR_W'(5): word = DATA_W'(32'h0109_6825);  // or   $t5,$t0,$t1
            ADDR_W'(6): word = DATA_W'(32'hAC0A_0000);  // sw   $t2,0($zero)
            ADDR_W'(7): word = DATA_W'(32'h8C0E_0000);  // lw   $t6,0($zero)
            ADDR_W'(8): word = DATA_W'(32'h0128_782A);  // slt  $t7,$t1,$t0
            ADDR_W'(9): word = DATA_W'(32'h0800_0009);  // j    9
            default:    word = NOP_WORD;
        endcase
        return word;
    endfunction

    // NOTE: the ROM is pure combinational decode, so there is no array to reset;
    // only the output register is cleared, and it uses <= like all clocked state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data <= '0;
        end else begin
            data <= rom_word(addr);
        end
    end

endmodule

// File: tb/tb_instruction_memory.sv
// Self-checking bench for instruction_memory: directed plan plus randomized reads
// checked against a table-driven reference array.
module tb_instruction_memory;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk;
    logic              rst;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;

    int tests_run;
    int tests_failed;

    logic [DATA_W-1:0] model_rom [DEPTH];

    instruction_memory #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .NOP_WORD(32'h0000_0000)
    ) dut (
        .clk (clk),
        .rst (rst),
        .addr(addr),
        .data(data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DATA_W-1:0] observed,
                         input logic [DATA_W-1:0] expected);
        tests_run++;
        assert (observed === expected)
        else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [ADDR_W-1:0] seq [4];
        logic [DATA_W-1:0] held;
        int unsigned       a;

        tests_run    = 0;
        tests_failed = 0;

        foreach (model_rom[i]) model_rom[i] = 32'h0000_0000;
        model_rom[0] = 32'h2008_0005;
        model_rom[1] = 32'h2009_0003;
        model_rom[2] = 32'h0109_5020;
        model_rom[3] = 32'h0109_5822;
        model_rom[4] = 32'h0109_6024;
        model_rom[5] = 32'h0109_6825;
        model_rom[6] = 32'hAC0A_0000;
        model_rom[7] = 32'h8C0E_0000;
        model_rom[8] = 32'h0128_782A;
        model_rom[9] = 32'h0800_0009;

        // Reset held with clocks running: output stays zero regardless of addr.
        rst  = 1'b1;
        addr = '0;
        #1;
        check("reset_async_start", data, 32'h0);
        for (int i = 0; i < 3; i++) begin
            addr = ADDR_W'(i + 1);
            tick();
            check("reset_hold", data, 32'h0);
        end

        // Sequential fetch: first edge after release already returns mem[0].
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            addr = ADDR_W'(i);
            tick();
            check($sformatf("seq_fetch_%0d", i), data, model_rom[i]);
        end

        // Unprogrammed region including the last index.
        addr = ADDR_W'(10);
        tick();
        check("nop_addr_10", data, model_rom[10]);
        addr = ADDR_W'(1023);
        tick();
        check("nop_addr_1023", data, model_rom[1023]);

        // Latency/hold: an addr change between edges does not reach data early.
        addr = ADDR_W'(3);
        tick();
        check("hold_addr3", data, 32'h0109_5822);
        addr = ADDR_W'(5);
        #3;
        check("hold_between_edges", data, 32'h0109_5822);
        tick();
        check("hold_next_edge", data, 32'h0109_6825);

        // Directed random-access order.
        seq[0] = ADDR_W'(9);
        seq[1] = ADDR_W'(0);
        seq[2] = ADDR_W'(7);
        seq[3] = ADDR_W'(2);
        for (int i = 0; i < 4; i++) begin
            addr = seq[i];
            tick();
            check($sformatf("rand_access_%0d", i), data, model_rom[seq[i]]);
        end

        // Reset pulse mid-stream: async clear, then resume on first edge after release.
        addr = ADDR_W'(4);
        tick();
        check("pre_reset_addr4", data, 32'h0109_6024);
        #2;
        rst = 1'b1;
        #1;
        check("reset_mid_cycle_async", data, 32'h0);
        tick();
        check("reset_pulse_edge", data, 32'h0);
        rst = 1'b0;
        tick();
        check("post_reset_addr4", data, 32'h0109_6024);

        // Randomized reads, with a mid-cycle addr change checked for hold each time.
        for (int i = 0; i < 200; i++) begin
            a    = $urandom_range(0, DEPTH - 1);
            addr = ADDR_W'(a);
            tick();
            check($sformatf("random_read_%0d", a), data, model_rom[a]);
            held = model_rom[a];
            addr = ADDR_W'($urandom_range(0, DEPTH - 1));
            #2;
            check("random_hold", data, held);
        end

        // Low-address sweep with random jumps biased into the programmed region.
        for (int i = 0; i < 40; i++) begin
            a    = $urandom_range(0, 15);
            addr = ADDR_W'(a);
            tick();
            check($sformatf("low_read_%0d", a), data, model_rom[a]);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
